hrtf_addr_sequencer: RTL and testbench

//  Multi-channel HRTF coefficient address sequencer: on a per-sample trigger from the I2S front end, walks the

---
 rtl/hrtf_pkg.sv | 27 ++
 rtl/hrtf_tap_counter.sv | 52 +++++
 rtl/hrtf_addr_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_hrtf_addr_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hrtf_pkg.sv
// Shared types and helpers for the HRTF coefficient address sequencer.
//   state_e      : sequencer FSM states
//   idx_width    : index width for a count, at least one bit
//   pack_addr    : concatenates {ch, angle, tap} into a zero-extended word
package hrtf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width needed to index n items; a single item still gets one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Coefficient address layout: {zero-pad, ch, angle, tap}.
  function automatic logic [63:0] pack_addr(input logic [31:0]  ch,
                                            input logic [31:0]  ang,
                                            input logic [31:0]  tap,
                                            input int unsigned  ang_w,
                                            input int unsigned  tap_w);
    return (64'(ch) << (ang_w + tap_w)) | (64'(ang) << tap_w) | 64'(tap);
  endfunction

endpackage

// File: rtl/hrtf_tap_counter.sv
// Nested tap/channel counter for the HRTF address sequencer.
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   load            : restart at ch=0, tap=0 (has priority over en)
//   en              : advance one tap; tap wrap advances the channel
//   tap, ch         : current position (registered)
//   tap_first_c     : tap == 0
//   tap_last_c      : tap == NUM_TAPS-1
//   wrap_all_c      : last tap of last channel
module hrtf_tap_counter #(
  parameter int unsigned NUM_TAPS = 128,
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned TAP_W    = 7,
  parameter int unsigned CH_W     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  output logic [TAP_W-1:0] tap,
  output logic [CH_W-1:0]  ch,
  output logic             tap_first_c,
  output logic             tap_last_c,
  output logic             wrap_all_c
);

  logic ch_last_c;

  assign tap_first_c = (tap == '0);
  assign tap_last_c  = (tap == TAP_W'(NUM_TAPS - 1));
  assign ch_last_c   = (ch  == CH_W'(NUM_CH - 1));
  assign wrap_all_c  = tap_last_c && ch_last_c;

  // Tap counts fastest; channel steps on each tap wrap and wraps after the last channel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tap <= '0;
      ch  <= '0;
    end else if (load) begin
      tap <= '0;
      ch  <= '0;
    end else if (en) begin
      if (tap_last_c) begin
        tap <= '0;
        ch  <= ch_last_c ? '0 : ch + CH_W'(1);
      end else begin
        tap <= tap + TAP_W'(1);
      end
    end
  end

endmodule

// File: rtl/hrtf_addr_sequencer.sv
// Multi-channel HRTF coefficient address sequencer. On each accepted sample
// trigger it walks NUM_CH*NUM_TAPS consecutive coefficient addresses for the
// latched angle, tagging first/last taps for the FIR MAC.
// Optional feature macro: HRTF_PENDING_TRIGGER_EN (one-deep pending trigger slot).
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   start_trigger  : one-cycle sample strobe
//   angle_index    : requested angle, sampled when a trigger is accepted
//   clr_overrun    : clears overrun (a same-cycle set wins)
//   bram_addr      : {zero-pad, ch, angle, tap}; holds when addr_valid=0
//   addr_valid     : address valid / MAC enable
//   ch_idx         : channel of the current address
//   tap_first      : first tap of a channel (accumulator clear)
//   tap_last       : last tap of a channel (result capture)
//   conv_done      : one-cycle pulse after the final address
//   busy           : run or done phase in progress
//   angle_err      : sticky, an out-of-range angle was accepted and clamped
//   overrun        : sticky, a trigger was dropped
module hrtf_addr_sequencer
  import hrtf_pkg::*;
#(
  parameter  int unsigned NUM_TAPS   = 128,
  parameter  int unsigned NUM_ANGLES = 256,
  parameter  int unsigned NUM_CH     = 2,
  parameter  int unsigned ADDR_W     = 16,
  localparam int unsigned TAP_W      = idx_width(NUM_TAPS),
  localparam int unsigned ANG_W      = idx_width(NUM_ANGLES),
  localparam int unsigned CH_W       = idx_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_trigger,
  input  logic [ANG_W-1:0]  angle_index,
  input  logic              clr_overrun,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              addr_valid,
  output logic [CH_W-1:0]   ch_idx,
  output logic              tap_first,
  output logic              tap_last,
  output logic              conv_done,
  output logic              busy,
  output logic              angle_err,
  output logic              overrun
);

  if (ADDR_W < CH_W + ANG_W + TAP_W) begin : g_addr_w_check
    $error("hrtf_addr_sequencer: ADDR_W too narrow for {ch, angle, tap}");
  end

  state_e            state_q, state_d;
  logic [ANG_W-1:0]  angle_q;
  logic [ANG_W-1:0]  angle_d;
  logic [ANG_W-1:0]  angle_clamp_c;
  logic              ang_oob_c;
  logic              angle_ld;
  logic              err_set;
  logic              drop;
  logic              cnt_load;
  logic              cnt_en;
  logic [TAP_W-1:0]  tap;
  logic [CH_W-1:0]   ch;
  logic              tap_first_c;
  logic              tap_last_c;
  logic              wrap_all_c;
  logic              run_c;

  assign ang_oob_c     = (32'(angle_index) >= NUM_ANGLES);
  assign angle_clamp_c = ang_oob_c ? ANG_W'(NUM_ANGLES - 1) : angle_index;
  assign run_c         = (state_q == ST_RUN);

  hrtf_tap_counter #(
    .NUM_TAPS (NUM_TAPS),
    .NUM_CH   (NUM_CH),
    .TAP_W    (TAP_W),
    .CH_W     (CH_W)
  ) u_tap_counter (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (cnt_load),
    .en          (cnt_en),
    .tap         (tap),
    .ch          (ch),
    .tap_first_c (tap_first_c),
    .tap_last_c  (tap_last_c),
    .wrap_all_c  (wrap_all_c)
  );

`ifdef HRTF_PENDING_TRIGGER_EN
  logic              pend_q;
  logic [ANG_W-1:0]  pend_angle_q;
  logic              pend_set;
  logic              pend_clr;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and control strobes
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    angle_ld = 1'b0;
    angle_d  = angle_clamp_c;
    err_set  = 1'b0;
    drop     = 1'b0;
`ifdef HRTF_PENDING_TRIGGER_EN
    pend_set = 1'b0;
    pend_clr = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start_trigger) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
          angle_ld = 1'b1;
          err_set  = ang_oob_c;
        end
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (wrap_all_c) state_d = ST_DONE;
        if (start_trigger) begin
`ifdef HRTF_PENDING_TRIGGER_EN
          if (pend_q) begin
            drop = 1'b1;
          end else begin
            pend_set = 1'b1;
            err_set  = ang_oob_c;
          end
`else
          drop = 1'b1;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef HRTF_PENDING_TRIGGER_EN
        // Chain straight into the next run so back-to-back samples have no gap.
        if (pend_q) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
          angle_ld = 1'b1;
          angle_d  = pend_angle_q;
          pend_clr = 1'b1;
          drop     = start_trigger;
        end else if (start_trigger) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
          angle_ld = 1'b1;
          err_set  = ang_oob_c;
        end
`else
        drop = start_trigger;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef HRTF_PENDING_TRIGGER_EN
  // One-deep pending slot; the first stored angle is kept until consumed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q       <= 1'b0;
      pend_angle_q <= '0;
    end else if (pend_set) begin
      pend_q       <= 1'b1;
      pend_angle_q <= angle_clamp_c;
    end else if (pend_clr) begin
      pend_q       <= 1'b0;
    end
  end
`endif

  // Angle latch and sticky status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      angle_q   <= '0;
      angle_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (angle_ld) angle_q <= angle_d;
      if (err_set)  angle_err <= 1'b1;
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // Output register stage: one cycle behind the FSM/counter position.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bram_addr  <= '0;
      addr_valid <= 1'b0;
      ch_idx     <= '0;
      tap_first  <= 1'b0;
      tap_last   <= 1'b0;
      conv_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      addr_valid <= run_c;
      tap_first  <= run_c && tap_first_c;
      tap_last   <= run_c && tap_last_c;
      conv_done  <= (state_q == ST_DONE);
      busy       <= (state_q != ST_IDLE);
      if (run_c) begin
        bram_addr <= ADDR_W'(pack_addr(32'(ch), 32'(angle_q), 32'(tap), ANG_W, TAP_W));
        ch_idx    <= ch;
      end
    end
  end

endmodule

// File: tb/tb_hrtf_addr_sequencer.sv
// Directed bench for hrtf_addr_sequencer: default config, clamped-angle config
// (NUM_ANGLES=200) and a minimal config (NUM_CH=1, NUM_TAPS=4).
module tb_hrtf_addr_sequencer;

`ifdef HRTF_PENDING_TRIGGER_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // u0: defaults
  logic        trig0, clr0;
  logic [7:0]  ang0;
  logic [15:0] addr0;
  logic        valid0, ch0, first0, last0, done0, busy0, aerr0, ovr0;

  // u1: NUM_ANGLES=200
  logic        trig1, clr1;
  logic [7:0]  ang1;
  logic [15:0] addr1;
  logic        valid1, ch1, first1, last1, done1, busy1, aerr1, ovr1;

  // u2: NUM_CH=1, NUM_TAPS=4
  logic        trig2, clr2;
  logic [7:0]  ang2;
  logic [15:0] addr2;
  logic        valid2, ch2, first2, last2, done2, busy2, aerr2, ovr2;

  hrtf_addr_sequencer u0 (
    .clk(clk), .reset_n(reset_n), .start_trigger(trig0), .angle_index(ang0),
    .clr_overrun(clr0), .bram_addr(addr0), .addr_valid(valid0), .ch_idx(ch0),
    .tap_first(first0), .tap_last(last0), .conv_done(done0), .busy(busy0),
    .angle_err(aerr0), .overrun(ovr0)
  );

  hrtf_addr_sequencer #(.NUM_ANGLES(200)) u1 (
    .clk(clk), .reset_n(reset_n), .start_trigger(trig1), .angle_index(ang1),
    .clr_overrun(clr1), .bram_addr(addr1), .addr_valid(valid1), .ch_idx(ch1),
    .tap_first(first1), .tap_last(last1), .conv_done(done1), .busy(busy1),
    .angle_err(aerr1), .overrun(ovr1)
  );

  hrtf_addr_sequencer #(.NUM_CH(1), .NUM_TAPS(4)) u2 (
    .clk(clk), .reset_n(reset_n), .start_trigger(trig2), .angle_index(ang2),
    .clr_overrun(clr2), .bram_addr(addr2), .addr_valid(valid2), .ch_idx(ch2),
    .tap_first(first2), .tap_last(last2), .conv_done(done2), .busy(busy2),
    .angle_err(aerr2), .overrun(ovr2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_addr0(input int idx, input int ang);
    return 32'(((idx / 128) << 15) | (ang << 7) | (idx % 128));
  endfunction

  initial begin
    reset_n = 1'b0;
    trig0 = 0; clr0 = 0; ang0 = 0;
    trig1 = 0; clr1 = 0; ang1 = 0;
    trig2 = 0; clr2 = 0; ang2 = 0;
    repeat (3) step();

    // Reset state
    check("rst_valid", 32'(valid0), 0);
    check("rst_addr",  32'(addr0),  0);
    check("rst_busy",  32'(busy0),  0);
    check("rst_done",  32'(done0),  0);
    check("rst_ovr",   32'(ovr0),   0);
    check("rst_aerr1", 32'(aerr1),  0);
    check("rst_valid2", 32'(valid2), 0);
    reset_n = 1'b1;
    repeat (2) step();

    // Run 1: angle 5, angle change and extra triggers mid-run
    ang0 = 8'd5; trig0 = 1; step(); trig0 = 0;
    check("acc_aerr", 32'(aerr0), 0);
    for (int i = 1; i <= 256; i++) begin
      step();
      check("r1_valid", 32'(valid0), 1);
      check("r1_addr",  32'(addr0), exp_addr0(i - 1, 5));
      if (i == 1 || i == 128 || i == 129 || i == 256) begin
        check("r1_first", 32'(first0), 32'(i == 1 || i == 129));
        check("r1_last",  32'(last0),  32'(i == 128 || i == 256));
        check("r1_ch",    32'(ch0),    32'(i > 128));
        check("r1_busy",  32'(busy0),  1);
      end
      if (i == 100) check("r1_ovr_first_trig", 32'(ovr0), PEND ? 32'd0 : 32'd1);
      if (i == 121) check("r1_ovr_set_wins", 32'(ovr0), 1);
      trig0 = 0; clr0 = 0;
      if (i == 39) ang0 = 8'd9;
      if (i == 89) trig0 = 1;
      if (i == 119) begin trig0 = 1; clr0 = 1; ang0 = 8'd11; end
    end
    step();
    check("r1_done",      32'(done0),  1);
    check("r1_done_vld",  32'(valid0), 0);
    check("r1_done_busy", 32'(busy0),  1);
    check("r1_hold_addr", 32'(addr0),  32'h82FF);
    check("r1_done_last", 32'(last0),  0);

`ifdef HRTF_PENDING_TRIGGER_EN
    // Pending run chains with no gap and uses the first stored angle (9)
    for (int i = 1; i <= 256; i++) begin
      step();
      check("r2_valid", 32'(valid0), 1);
      check("r2_addr",  32'(addr0), exp_addr0(i - 1, 9));
      if (i == 1) begin
        check("r2_first", 32'(first0), 1);
        check("r2_nodone", 32'(done0), 0);
      end
    end
    step();
    check("r2_done", 32'(done0), 1);
    step();
    check("r2_idle_busy", 32'(busy0), 0);
    check("r2_idle_vld",  32'(valid0), 0);
`else
    for (int i = 0; i < 4; i++) begin
      step();
      check("r1_idle_vld",  32'(valid0), 0);
      check("r1_idle_busy", 32'(busy0),  0);
      check("r1_idle_done", 32'(done0),  0);
    end
`endif
    check("ovr_sticky", 32'(ovr0), 1);
    clr0 = 1; step(); clr0 = 0;
    check("ovr_clr", 32'(ovr0), 0);
    step();

    // Reset mid-run aborts without conv_done, then a clean restart
    ang0 = 8'd3; trig0 = 1; step(); trig0 = 0;
    for (int i = 1; i < 70; i++) step();
    check("pre_rst_addr", 32'(addr0), exp_addr0(68, 3));
    reset_n = 1'b0; step();
    check("mrst_valid", 32'(valid0), 0);
    check("mrst_addr",  32'(addr0),  0);
    check("mrst_first", 32'(first0), 0);
    check("mrst_busy",  32'(busy0),  0);
    check("mrst_done",  32'(done0),  0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_nodone", 32'(done0), 0);
      check("mrst_novld",  32'(valid0), 0);
    end
    trig0 = 1; step(); trig0 = 0;
    step();
    check("rs_valid", 32'(valid0), 1);
    check("rs_addr",  32'(addr0), 32'h0180);
    check("rs_first", 32'(first0), 1);
    check("rs_ch",    32'(ch0), 0);
    for (int i = 2; i <= 256; i++) step();
    check("rs_last_addr", 32'(addr0), 32'h81FF);
    step();
    check("rs_done", 32'(done0), 1);
    step();

    // Out-of-range angle is clamped to 199
    ang1 = 8'd250; trig1 = 1; step(); trig1 = 0;
    check("u1_aerr", 32'(aerr1), 1);
    for (int i = 1; i <= 256; i++) begin
      step();
      if (i == 1)   check("u1_addr_first", 32'(addr1), 32'h6380);
      if (i == 129) check("u1_addr_ch1",   32'(addr1), 32'hE380);
      if (i == 256) check("u1_addr_last",  32'(addr1), 32'hE3FF);
    end
    step();
    check("u1_done", 32'(done1), 1);
    check("u1_aerr_sticky", 32'(aerr1), 1);

    // Minimal config: single channel, four taps
    ang2 = 8'd5; trig2 = 1; step(); trig2 = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("u2_valid", 32'(valid2), 1);
      check("u2_addr",  32'(addr2), 32'(8'h13 + i));
      check("u2_first", 32'(first2), 32'(i == 1));
      check("u2_last",  32'(last2),  32'(i == 4));
      check("u2_ch",    32'(ch2), 0);
    end
    step();
    check("u2_done",     32'(done2),  1);
    check("u2_done_vld", 32'(valid2), 0);
    check("u2_hold",     32'(addr2),  32'h17);
    step();
    check("u2_done_pulse", 32'(done2), 0);
    check("u2_idle_busy",  32'(busy2), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
